eth_speed_detect: RTL and testbench
===================================

// Module: eth_speed_detect
// PURPOSE
//  Multi-channel PHY line-rate detector for tri-speed GMII/MII MACs.
//  Per channel: measures the frequency of a prescaled PHY RX clock toggle against local clk.
//  Classifies each channel as 10M, 100M or 1000M; a hysteresis filter commits the result.
//  Drives speed/mii_select for N MAC instances from one shared reference clock.
// PARAMETERS
//  CHANNELS     4   number of independent channels
//  REF_W        7   reference counter width; all-ones = timeout => 10M
//  EDGE_W       2   edge counter width; all-ones ends a measurement window
//  THRESH_100M  32  ref count >= this at window end => 100M, else 1000M (must be < 2**REF_W-1)
//  HYST         1   consecutive identical classifications required to commit (1..15)
// PORTS
//  clk            in   1           reference clock (gtx_clk domain)
//  rst            in   1           asynchronous reset, active-high
//  rx_prescale    in   CHANNELS    per-channel toggle, e.g. bit 2 of a free-running rx_clk counter; asynchronous to clk
//  cfg_enable     in   CHANNELS    per-channel measurement enable
//  speed          out  2*CHANNELS  committed speed {ch*2+1:ch*2}: 00=10M 01=100M 10=1000M
//  mii_select     out  CHANNELS    1 when committed speed is 10M/100M
//  speed_locked   out  CHANNELS    set on first commit after reset; sticky
//  speed_change   out  CHANNELS    1-cycle pulse when committed speed changes value
// BEHAVIOUR
//  Reset (async assert, sync release in design): speed=2'b10, mii_select=0, speed_locked=0,
//   speed_change=0, all counters/sync regs=0, candidate=2'b10.
//  Sync: 3-bit shift reg per channel; edge = sync[1]^sync[2]; 2-cycle sync + 1-cycle detect.
//  Every cycle with cfg_enable=1: ref_cnt+=1; edge_cnt+=1 when edge.
//  Window end, evaluated on registered values, edge has priority:
//   edge_cnt==all-ones: class = (ref_cnt>=THRESH_100M) ? 100M : 1000M; clear both counters.
//   else ref_cnt==all-ones: class = 10M; clear both counters.
//  Hysteresis: class==candidate => hyst_cnt+=1 (saturating at HYST), else candidate=class, hyst_cnt=1.
//   Commit when hyst_cnt reaches HYST in that same cycle; speed/mii_select update the next cycle.
//   HYST=1 commits every classification.
//  speed_change pulses with the speed register update only if the value differs; speed_locked sets on first commit.
//  cfg_enable=0: ref_cnt, edge_cnt and hyst_cnt held at 0; speed/locked held; sync chain keeps running.
//   Re-enable starts a fresh window.
//  Channels fully independent; no cross-channel arbitration.
//  rst mid-window: everything returns to reset values immediately; no speed_change pulse.
// CONFIGURATION
//  ETH_SPEED_DETECT_DEBUG_EN defined: adds output meas_ref_cnt [REF_W*CHANNELS] out,
//   holding ref_cnt latched at each window end (reset 0), plus meas_valid [CHANNELS], a 1-cycle pulse per window end.
//  Undefined: these ports and their registers do not exist; all other behaviour is identical.
// STRUCTURE
//  Package eth_speed_pkg: localparams SPEED_10M=2'b00, SPEED_100M=2'b01, SPEED_1000M=2'b10, SPEED_W=2.
//  Sub-module eth_speed_detect_ch: one channel (sync, counters, classifier, hysteresis),
//   instantiated CHANNELS times in a generate loop; top level only concatenates ports.
// TESTING
//  Defaults; clk 125MHz; rx_prescale period 8 clk (1000M rx) => speed=10, mii_select=0,
//   speed_locked=1 within 40 cycles, no speed_change.
//  ch0 rx_prescale period 40 clk (25MHz) => ch0 speed=01, mii_select=1, one speed_change pulse; other channels unaffected.
//  ch1 rx_prescale stuck at 0 => ref timeout after 127 cycles => speed=00, mii_select=1.
//  HYST=3; alternate 100M/1000M windows => speed never changes;
//   3 consecutive 100M windows => commit 01 with exactly one pulse.
//  Edge and timeout in same cycle (edge_cnt=3, ref_cnt=127) => classified 100M, not 10M.
//  cfg_enable=0 for 500 cycles => speed held, no pulses; assert rst mid-window => all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/eth_speed_pkg.sv
// ============================================================================
// Module : eth_speed_pkg
// Brief  : Shared speed encodings and helpers for the tri-speed line-rate detector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package eth_speed_pkg;

  localparam int SPEED_W = 2;

  localparam logic [SPEED_W-1:0] SPEED_10M   = 2'b00;
  localparam logic [SPEED_W-1:0] SPEED_100M  = 2'b01;
  localparam logic [SPEED_W-1:0] SPEED_1000M = 2'b10;

  typedef logic [SPEED_W-1:0] speed_t;

  // The MAC runs its MII datapath for every rate below gigabit.
  function automatic logic is_mii(input speed_t s);
    return (s != SPEED_1000M);
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_speed_detect_ch.sv
// ============================================================================
// Module : eth_speed_detect_ch
// Brief  : One channel: rx toggle sync, window counters, classifier, hysteresis.
//          Optional ETH_SPEED_DETECT_DEBUG_EN exposes the latched window length.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eth_speed_detect_ch
  import eth_speed_pkg::*;
#(
  parameter int REF_W       = 7,
  parameter int EDGE_W      = 2,
  parameter int THRESH_100M = 32,
  parameter int HYST        = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_prescale,
  input  logic               cfg_enable,
  output logic [SPEED_W-1:0] speed,
  output logic               mii_select,
  output logic               speed_locked,
  output logic               speed_change
`ifdef ETH_SPEED_DETECT_DEBUG_EN
  ,
  output logic [REF_W-1:0]   meas_ref_cnt,
  output logic               meas_valid
`endif
);

  localparam logic [REF_W-1:0] c_thresh = REF_W'(THRESH_100M);
  localparam logic [3:0]       c_hyst   = 4'(HYST);

  logic [2:0]        r_sync;
  logic [REF_W-1:0]  r_ref_cnt;
  logic [EDGE_W-1:0] r_edge_cnt;
  logic [3:0]        r_hyst_cnt;
  speed_t            r_candidate;
  speed_t            r_speed;
  logic              r_mii_select;
  logic              r_locked;
  logic              r_change;

  logic   w_edge;
  logic   w_edge_done;
  logic   w_ref_done;
  logic   w_win_end;
  speed_t w_class;
  logic   w_same;
  logic [3:0] w_hyst_next;
  logic   w_commit;

  assign w_edge      = r_sync[1] ^ r_sync[2];
  assign w_edge_done = (r_edge_cnt == {EDGE_W{1'b1}});
  assign w_ref_done  = (r_ref_cnt == {REF_W{1'b1}});
  assign w_win_end   = cfg_enable && (w_edge_done || w_ref_done);

  // A full edge count wins over a coincident timeout.
  assign w_class = w_edge_done ? ((r_ref_cnt >= c_thresh) ? SPEED_100M : SPEED_1000M)
                               : SPEED_10M;

  assign w_same      = (w_class == r_candidate);
  assign w_hyst_next = w_same ? ((r_hyst_cnt >= c_hyst) ? c_hyst : r_hyst_cnt + 4'd1) : 4'd1;
  assign w_commit    = w_win_end && (w_hyst_next == c_hyst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync       <= '0;
      r_ref_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_hyst_cnt   <= '0;
      r_candidate  <= SPEED_1000M;
      r_speed      <= SPEED_1000M;
      r_mii_select <= 1'b0;
      r_locked     <= 1'b0;
      r_change     <= 1'b0;
    end else begin
      r_sync   <= {r_sync[1:0], rx_prescale};
      r_change <= 1'b0;
      if (!cfg_enable) begin
        r_ref_cnt  <= '0;
        r_edge_cnt <= '0;
        r_hyst_cnt <= '0;
      end else if (w_win_end) begin
        r_ref_cnt   <= '0;
        r_edge_cnt  <= '0;
        r_candidate <= w_class;
        r_hyst_cnt  <= w_hyst_next;
        if (w_commit) begin
          r_speed      <= w_class;
          r_mii_select <= is_mii(w_class);
          r_locked     <= 1'b1;
          r_change     <= (w_class != r_speed);
        end
      end else begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
        if (w_edge) begin
          r_edge_cnt <= r_edge_cnt + 1'b1;
        end
      end
    end
  end

  assign speed        = r_speed;
  assign mii_select   = r_mii_select;
  assign speed_locked = r_locked;
  assign speed_change = r_change;

`ifdef ETH_SPEED_DETECT_DEBUG_EN
  logic [REF_W-1:0] r_meas_ref_cnt;
  logic             r_meas_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meas_ref_cnt <= '0;
      r_meas_valid   <= 1'b0;
    end else begin
      r_meas_valid <= w_win_end;
      if (w_win_end) begin
        r_meas_ref_cnt <= r_ref_cnt;
      end
    end
  end

  assign meas_ref_cnt = r_meas_ref_cnt;
  assign meas_valid   = r_meas_valid;
`endif

endmodule

`default_nettype wire

// File: rtl/eth_speed_detect.sv
// ============================================================================
// Module : eth_speed_detect
// Brief  : Multi-channel PHY line-rate detector driving speed/mii_select per MAC.
//          Define ETH_SPEED_DETECT_DEBUG_EN to add meas_ref_cnt/meas_valid ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module eth_speed_detect
  import eth_speed_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int REF_W       = 7,
  parameter int EDGE_W      = 2,
  parameter int THRESH_100M = 32,
  parameter int HYST        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           rx_prescale,
  input  logic [CHANNELS-1:0]           cfg_enable,
  output logic [SPEED_W*CHANNELS-1:0]   speed,
  output logic [CHANNELS-1:0]           mii_select,
  output logic [CHANNELS-1:0]           speed_locked,
  output logic [CHANNELS-1:0]           speed_change
`ifdef ETH_SPEED_DETECT_DEBUG_EN
  ,
  output logic [REF_W*CHANNELS-1:0]     meas_ref_cnt,
  output logic [CHANNELS-1:0]           meas_valid
`endif
);

  // Assert immediately, release two clocks after rst falls.
  logic [1:0] r_rst_pipe;
  logic       w_rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_pipe <= 2'b11;
    end else begin
      r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
  end

  assign w_rst = r_rst_pipe[1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    eth_speed_detect_ch #(
      .REF_W       (REF_W),
      .EDGE_W      (EDGE_W),
      .THRESH_100M (THRESH_100M),
      .HYST        (HYST)
    ) u_ch (
      .clk          (clk),
      .rst          (w_rst),
      .rx_prescale  (rx_prescale[g]),
      .cfg_enable   (cfg_enable[g]),
      .speed        (speed[g*SPEED_W +: SPEED_W]),
      .mii_select   (mii_select[g]),
      .speed_locked (speed_locked[g]),
      .speed_change (speed_change[g])
`ifdef ETH_SPEED_DETECT_DEBUG_EN
      ,
      .meas_ref_cnt (meas_ref_cnt[g*REF_W +: REF_W]),
      .meas_valid   (meas_valid[g])
`endif
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_eth_speed_detect.sv
// ============================================================================
// Module : tb_eth_speed_detect
// Brief  : Self-checking bench for eth_speed_detect (HYST=1 and HYST=3 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_eth_speed_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rx;
  logic [3:0] en;
  logic [7:0] speed_a, speed_b;
  logic [3:0] mii_a, mii_b, lock_a, lock_b, chg_a, chg_b;

  always #4 clk = ~clk;

  eth_speed_detect dut_a (
    .clk(clk), .rst(rst), .rx_prescale(rx), .cfg_enable(en),
    .speed(speed_a), .mii_select(mii_a), .speed_locked(lock_a), .speed_change(chg_a)
  );

  eth_speed_detect #(.HYST(3)) dut_b (
    .clk(clk), .rst(rst), .rx_prescale(rx), .cfg_enable(en),
    .speed(speed_b), .mii_select(mii_b), .speed_locked(lock_b), .speed_change(chg_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: window counts as integers, hysteresis as the length of
  // the trailing run of identical classifications since enable/reset.
  int m_rel;
  bit m_hist[4][3];
  int m_rc[2][4], m_ec[2][4], m_last[2][4], m_run[2][4];
  int m_speed[2][4];
  bit m_lock[2][4], m_chg[2][4];
  int pulses_a[4], pulses_b[4];

  int hp_cur[4];
  int cnt[4];

  typedef struct packed {
    logic [3:0][8:0] hp;
    logic [3:0]      en;
    logic [15:0]     cycles;
    logic [7:0]      exp_speed;
    logic [3:0]      exp_mii;
    logic [3:0]      exp_lock;
    logic [3:0][1:0] exp_pulses;
  } vec_t;

  vec_t tv[5];

  task automatic model_reset();
    m_rel = 0;
    for (int ch = 0; ch < 4; ch++) begin
      for (int j = 0; j < 3; j++) m_hist[ch][j] = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_rc[d][ch] = 0; m_ec[d][ch] = 0; m_last[d][ch] = 2; m_run[d][ch] = 0;
        m_speed[d][ch] = 2; m_lock[d][ch] = 1'b0; m_chg[d][ch] = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    bit e[4];
    int cls;
    int hyst;
    if (rst) begin
      model_reset();
      return;
    end
    m_rel++;
    if (m_rel < 3) return;
    for (int ch = 0; ch < 4; ch++) begin
      e[ch] = m_hist[ch][1] ^ m_hist[ch][2];
      m_hist[ch][2] = m_hist[ch][1];
      m_hist[ch][1] = m_hist[ch][0];
      m_hist[ch][0] = rx[ch];
    end
    for (int d = 0; d < 2; d++) begin
      hyst = (d == 0) ? 1 : 3;
      for (int ch = 0; ch < 4; ch++) begin
        m_chg[d][ch] = 1'b0;
        if (!en[ch]) begin
          m_rc[d][ch] = 0; m_ec[d][ch] = 0; m_run[d][ch] = 0;
        end else if (m_ec[d][ch] == 3 || m_rc[d][ch] == 127) begin
          cls = (m_ec[d][ch] == 3) ? ((m_rc[d][ch] >= 32) ? 1 : 2) : 0;
          m_rc[d][ch] = 0; m_ec[d][ch] = 0;
          if (cls == m_last[d][ch]) m_run[d][ch]++;
          else begin m_last[d][ch] = cls; m_run[d][ch] = 1; end
          if (m_run[d][ch] >= hyst) begin
            m_chg[d][ch] = (cls != m_speed[d][ch]);
            m_speed[d][ch] = cls;
            m_lock[d][ch] = 1'b1;
          end
        end else begin
          m_rc[d][ch]++;
          if (e[ch]) m_ec[d][ch]++;
        end
      end
    end
  endtask

  function automatic logic [19:0] model_vec(int d);
    logic [19:0] v = '0;
    for (int ch = 0; ch < 4; ch++) begin
      v[12 + 2*ch +: 2] = 2'(m_speed[d][ch]);
      v[8 + ch] = (m_speed[d][ch] != 2);
      v[4 + ch] = m_lock[d][ch];
      v[ch]     = m_chg[d][ch];
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("model_hyst1", 32'({speed_a, mii_a, lock_a, chg_a}), 32'(model_vec(0)));
    chk("model_hyst3", 32'({speed_b, mii_b, lock_b, chg_b}), 32'(model_vec(1)));
    for (int ch = 0; ch < 4; ch++) begin
      pulses_a[ch] += int'(chg_a[ch]);
      pulses_b[ch] += int'(chg_b[ch]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic gen_cycle();
    for (int ch = 0; ch < 4; ch++) begin
      if (hp_cur[ch] == 0) rx[ch] = 1'b0;
      else begin
        cnt[ch]++;
        if (cnt[ch] >= hp_cur[ch]) begin cnt[ch] = 0; rx[ch] = ~rx[ch]; end
      end
    end
    cyc();
  endtask

  task automatic clear_pulses();
    for (int ch = 0; ch < 4; ch++) begin pulses_a[ch] = 0; pulses_b[ch] = 0; end
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    model_reset();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic async_reset(input bit explicit_chk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    if (explicit_chk) begin
      chk("rst_mid_speed", 32'(speed_a), 32'h aa);
      chk("rst_mid_mii",   32'(mii_a),   32'h0);
      chk("rst_mid_lock",  32'(lock_a),  32'h0);
      chk("rst_mid_chg",   32'(chg_a),   32'h0);
    end
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int wins[8] = '{4, 20, 4, 20, 4, 20, 20, 20};
    int sum;
    rst = 1'b0; rx = 4'h0; en = 4'h0;
    for (int ch = 0; ch < 4; ch++) begin hp_cur[ch] = 0; cnt[ch] = 0; end
    model_reset();

    tv[0] = '{hp: {9'd4, 9'd4, 9'd4, 9'd4},    en: 4'hf, cycles: 16'd60,  exp_speed: 8'b10101010,
              exp_mii: 4'b0000, exp_lock: 4'hf, exp_pulses: {2'd0, 2'd0, 2'd0, 2'd0}};
    tv[1] = '{hp: {9'd4, 9'd4, 9'd4, 9'd20},   en: 4'hf, cycles: 16'd300, exp_speed: 8'b10101001,
              exp_mii: 4'b0001, exp_lock: 4'hf, exp_pulses: {2'd0, 2'd0, 2'd0, 2'd1}};
    tv[2] = '{hp: {9'd4, 9'd4, 9'd0, 9'd20},   en: 4'hf, cycles: 16'd500, exp_speed: 8'b10100001,
              exp_mii: 4'b0011, exp_lock: 4'hf, exp_pulses: {2'd0, 2'd0, 2'd1, 2'd0}};
    tv[3] = '{hp: {9'd4, 9'd4, 9'd4, 9'd20},   en: 4'h0, cycles: 16'd500, exp_speed: 8'b10100001,
              exp_mii: 4'b0011, exp_lock: 4'hf, exp_pulses: {2'd0, 2'd0, 2'd0, 2'd0}};
    tv[4] = '{hp: {9'd20, 9'd4, 9'd20, 9'd200}, en: 4'hf, cycles: 16'd700, exp_speed: 8'b01100100,
              exp_mii: 4'b1011, exp_lock: 4'hf, exp_pulses: {2'd1, 2'd0, 2'd1, 2'd1}};

    // Power-on reset values
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("reset_speed", 32'(speed_a), 32'h aa);
    chk("reset_mii",   32'(mii_a),   32'h0);
    chk("reset_lock",  32'(lock_a),  32'h0);
    chk("reset_chg",   32'(chg_a),   32'h0);
    check_outputs();
    cyc();
    cyc();
    rst = 1'b0;

    // Table-driven rate scenarios
    for (int i = 0; i < 5; i++) begin
      for (int ch = 0; ch < 4; ch++) hp_cur[ch] = int'(tv[i].hp[ch]);
      en = tv[i].en;
      clear_pulses();
      repeat (int'(tv[i].cycles)) gen_cycle();
      chk($sformatf("vec%0d_speed", i), 32'(speed_a), 32'(tv[i].exp_speed));
      chk($sformatf("vec%0d_mii", i),   32'(mii_a),   32'(tv[i].exp_mii));
      chk($sformatf("vec%0d_lock", i),  32'(lock_a),  32'(tv[i].exp_lock));
      for (int ch = 0; ch < 4; ch++)
        chk($sformatf("vec%0d_pulses_ch%0d", i, ch), 32'(pulses_a[ch]), 32'(tv[i].exp_pulses[ch]));
    end

    // Third edge lands in the same cycle the reference counter hits all-ones
    rx = 4'h0; en = 4'h0;
    sync_reset();
    repeat (10) cyc();
    for (int k = 1; k <= 135; k++) begin
      rx = ((k >= 11 && k <= 20) || k >= 125) ? 4'hf : 4'h0;
      en = 4'hf;
      cyc();
      if (k == 127) chk("coinc_before", 32'(speed_a), 32'h aa);
      if (k == 128) begin
        chk("coinc_speed_100m", 32'(speed_a), 32'h55);
        chk("coinc_pulse",      32'(chg_a),   32'hf);
        chk("coinc_hyst3_hold", 32'(speed_b), 32'h aa);
      end
    end

    // HYST=3: alternating 1000M/100M windows, then three 100M windows
    rx = 4'h0; en = 4'hf;
    sync_reset();
    clear_pulses();
    for (int w = 0; w < 8; w++) begin
      for (int t = 0; t < 3; t++) begin
        repeat (wins[w]) cyc();
        rx = ~rx;
      end
      if (w == 4) begin
        repeat (8) cyc();
        sum = pulses_b[0] + pulses_b[1] + pulses_b[2] + pulses_b[3];
        chk("hyst3_alt_speed",  32'(speed_b), 32'h aa);
        chk("hyst3_alt_lock",   32'(lock_b),  32'h0);
        chk("hyst3_alt_pulses", 32'(sum),     32'h0);
      end
    end
    repeat (8) cyc();
    chk("hyst3_commit_speed", 32'(speed_b), 32'h55);
    for (int ch = 0; ch < 4; ch++)
      chk($sformatf("hyst3_pulse_ch%0d", ch), 32'(pulses_b[ch]), 32'h1);

    // Reset asserted in the middle of a window
    for (int ch = 0; ch < 4; ch++) hp_cur[ch] = 20;
    en = 4'hf;
    repeat (30) gen_cycle();
    async_reset(1'b1);

    // Randomized segments against the reference model
    for (int seg = 0; seg < 16; seg++) begin
      for (int ch = 0; ch < 4; ch++) begin
        case ($urandom_range(0, 4))
          0: hp_cur[ch] = 0;
          1: hp_cur[ch] = 4;
          2: hp_cur[ch] = 20;
          3: hp_cur[ch] = 200;
          default: hp_cur[ch] = int'($urandom_range(2, 70));
        endcase
      end
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
      if ($urandom_range(0, 4) == 0) async_reset(1'b0);
      repeat (int'($urandom_range(100, 300))) gen_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
